// File: rtl/alu_issue_stage.sv
// alu_issue_stage: RV32I decode/issue stage driving the ALU operand/control interface.
// Decodes each accepted instruction combinationally into operands a/b, a 4-bit ALU
// control code and branch/illegal flags. Decoded ops are held in an output register
// backed by one skid entry, so a stalled execute stage never loses or repeats an op.
// Optional build macro: ALU_ISSUE_PERF_EN adds saturating perf_issued / perf_stall counters.
module alu_issue_stage #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [31:0]  in_instr,
   input  logic [N-1:0] in_rs1,
   input  logic [N-1:0] in_rs2,
   input  logic [N-1:0] in_pc,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_a,
   output logic [N-1:0] out_b,
   output logic [3:0]   out_control,
   output logic         out_is_branch,
   output logic         out_illegal
`ifdef ALU_ISSUE_PERF_EN
   ,
   output logic [31:0]  perf_issued,
   output logic [31:0]  perf_stall
`endif
);

   // ALU control encodings
   localparam logic [3:0] ALU_NONE = 4'd0;
   localparam logic [3:0] ALU_AND  = 4'd1;
   localparam logic [3:0] ALU_OR   = 4'd2;
   localparam logic [3:0] ALU_XOR  = 4'd3;
   localparam logic [3:0] ALU_SLL  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_ADD  = 4'd8;
   localparam logic [3:0] ALU_SUB  = 4'd12;
   localparam logic [3:0] ALU_SLT  = 4'd13;
   localparam logic [3:0] ALU_SLTU = 4'd15;

   // RV32I major opcodes
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef struct packed {
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic [3:0]   control;
      logic         is_branch;
      logic         illegal;
   } op_t;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } occ_t;

   logic [6:0]   opcode_s;
   logic [2:0]   funct3_s;
   logic [6:0]   funct7_s;
   logic         f7_base_s;
   logic         f7_alt_s;
   logic [N-1:0] imm_i_s;
   logic [N-1:0] imm_s_s;
   logic [N-1:0] imm_u_s;
   logic [N-1:0] shamt_s;
   logic [N-1:0] four_s;
   op_t          raw_s;
   logic         bad_s;
   op_t          dec_s;

   occ_t         state_r;
   op_t          main_r;
   op_t          skid_r;
   logic         out_valid_r;
   logic         in_ready_r;
   logic         accept_s;
   logic         issue_s;

   assign opcode_s  = in_instr[6:0];
   assign funct3_s  = in_instr[14:12];
   assign funct7_s  = in_instr[31:25];
   assign f7_base_s = (funct7_s == F7_BASE);
   assign f7_alt_s  = (funct7_s == F7_ALT);

   // Immediates, all sign-extended to the datapath width except the shift amount
   assign imm_i_s = N'($signed(in_instr[31:20]));
   assign imm_s_s = N'($signed({in_instr[31:25], in_instr[11:7]}));
   assign imm_u_s = N'($signed({in_instr[31:12], 12'b0000_0000_0000}));
   assign shamt_s = N'(in_instr[24:20]);
   assign four_s  = N'(32'd4);

   // Combinational decode of the presented instruction into ALU operands and control
   always_comb begin
      raw_s = '0;
      bad_s = 1'b0;
      case (opcode_s)
         OPC_OP: begin
            raw_s.a = in_rs1;
            raw_s.b = in_rs2;
            case (funct3_s)
               3'b000: begin
                  raw_s.control = f7_alt_s ? ALU_SUB : ALU_ADD;
                  bad_s         = !(f7_base_s || f7_alt_s);
               end
               3'b001: begin raw_s.control = ALU_SLL;  bad_s = !f7_base_s; end
               3'b010: begin raw_s.control = ALU_SLT;  bad_s = !f7_base_s; end
               3'b011: begin raw_s.control = ALU_SLTU; bad_s = !f7_base_s; end
               3'b100: begin raw_s.control = ALU_XOR;  bad_s = !f7_base_s; end
               3'b101: begin
                  raw_s.control = f7_alt_s ? ALU_SRA : ALU_SRL;
                  bad_s         = !(f7_base_s || f7_alt_s);
               end
               3'b110: begin raw_s.control = ALU_OR;   bad_s = !f7_base_s; end
               3'b111: begin raw_s.control = ALU_AND;  bad_s = !f7_base_s; end
               default: bad_s = 1'b1;
            endcase
         end
         OPC_OP_IMM: begin
            raw_s.a = in_rs1;
            raw_s.b = imm_i_s;
            case (funct3_s)
               3'b000: raw_s.control = ALU_ADD;
               3'b001: begin
                  raw_s.b       = shamt_s;
                  raw_s.control = ALU_SLL;
                  bad_s         = !f7_base_s;
               end
               3'b010: raw_s.control = ALU_SLT;
               3'b011: raw_s.control = ALU_SLTU;
               3'b100: raw_s.control = ALU_XOR;
               3'b101: begin
                  raw_s.b       = shamt_s;
                  raw_s.control = f7_alt_s ? ALU_SRA : ALU_SRL;
                  bad_s         = !(f7_base_s || f7_alt_s);
               end
               3'b110: raw_s.control = ALU_OR;
               3'b111: raw_s.control = ALU_AND;
               default: bad_s = 1'b1;
            endcase
         end
         OPC_LUI: begin
            raw_s.b       = imm_u_s;
            raw_s.control = ALU_ADD;
         end
         OPC_AUIPC: begin
            raw_s.a       = in_pc;
            raw_s.b       = imm_u_s;
            raw_s.control = ALU_ADD;
         end
         OPC_JAL, OPC_JALR: begin
            raw_s.a       = in_pc;
            raw_s.b       = four_s;
            raw_s.control = ALU_ADD;
         end
         OPC_LOAD: begin
            raw_s.a       = in_rs1;
            raw_s.b       = imm_i_s;
            raw_s.control = ALU_ADD;
         end
         OPC_STORE: begin
            raw_s.a       = in_rs1;
            raw_s.b       = imm_s_s;
            raw_s.control = ALU_ADD;
         end
         OPC_BRANCH: begin
            raw_s.a         = in_rs1;
            raw_s.b         = in_rs2;
            raw_s.is_branch = 1'b1;
            case (funct3_s)
               3'b000, 3'b001: raw_s.control = ALU_SUB;
               3'b100, 3'b101: raw_s.control = ALU_SLT;
               3'b110, 3'b111: raw_s.control = ALU_SLTU;
               default:        bad_s = 1'b1;
            endcase
         end
         default: bad_s = 1'b1;
      endcase
   end

   // Undecodable ops still travel down the pipe, but with every payload field cleared
   assign dec_s = bad_s ? '{a: '0, b: '0, control: ALU_NONE, is_branch: 1'b0, illegal: 1'b1}
                        : raw_s;

   assign accept_s = in_valid && in_ready_r;
   assign issue_s  = out_valid_r && out_ready;

   // Occupancy FSM: output register plus one skid entry, strictly FIFO
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_EMPTY;
         main_r      <= '0;
         skid_r      <= '0;
         out_valid_r <= 1'b0;
         in_ready_r  <= 1'b1;
      end else begin
         case (state_r)
            ST_EMPTY: begin
               if (accept_s) begin
                  main_r      <= dec_s;
                  out_valid_r <= 1'b1;
                  state_r     <= ST_ONE;
               end
            end
            ST_ONE: begin
               if (accept_s && issue_s) begin
                  main_r <= dec_s;
               end else if (accept_s) begin
                  skid_r     <= dec_s;
                  in_ready_r <= 1'b0;
                  state_r    <= ST_TWO;
               end else if (issue_s) begin
                  out_valid_r <= 1'b0;
                  state_r     <= ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (issue_s) begin
                  main_r     <= skid_r;
                  in_ready_r <= 1'b1;
                  state_r    <= ST_ONE;
               end
            end
            default: begin
               out_valid_r <= 1'b0;
               in_ready_r  <= 1'b1;
               state_r     <= ST_EMPTY;
            end
         endcase
      end
   end

   assign in_ready      = in_ready_r;
   assign out_valid     = out_valid_r;
   assign out_a         = main_r.a;
   assign out_b         = main_r.b;
   assign out_control   = main_r.control;
   assign out_is_branch = main_r.is_branch;
   assign out_illegal   = main_r.illegal;

`ifdef ALU_ISSUE_PERF_EN
   logic [31:0] perf_issued_r;
   logic [31:0] perf_stall_r;

   // Saturating counters of output transfers and backpressured cycles
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_issued_r <= 32'd0;
         perf_stall_r  <= 32'd0;
      end else begin
         if (issue_s && (perf_issued_r != 32'hFFFF_FFFF)) begin
            perf_issued_r <= perf_issued_r + 32'd1;
         end
         if (out_valid_r && !out_ready && (perf_stall_r != 32'hFFFF_FFFF)) begin
            perf_stall_r <= perf_stall_r + 32'd1;
         end
      end
   end

   assign perf_issued = perf_issued_r;
   assign perf_stall  = perf_stall_r;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: table of decode vectors streamed
// back-to-back, then hand-written backpressure and mid-fill reset sequences.
module tb_alu_issue_stage;

   localparam int N  = 32;
   localparam int NV = 17;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [31:0]  in_instr;
   logic [N-1:0] in_rs1;
   logic [N-1:0] in_rs2;
   logic [N-1:0] in_pc;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] out_a;
   logic [N-1:0] out_b;
   logic [3:0]   out_control;
   logic         out_is_branch;
   logic         out_illegal;
`ifdef ALU_ISSUE_PERF_EN
   logic [31:0]  perf_issued;
   logic [31:0]  perf_stall;
`endif

   alu_issue_stage #(.N(N)) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_instr      (in_instr),
      .in_rs1        (in_rs1),
      .in_rs2        (in_rs2),
      .in_pc         (in_pc),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_a         (out_a),
      .out_b         (out_b),
      .out_control   (out_control),
      .out_is_branch (out_is_branch),
      .out_illegal   (out_illegal)
`ifdef ALU_ISSUE_PERF_EN
      ,
      .perf_issued   (perf_issued),
      .perf_stall    (perf_stall)
`endif
   );

   typedef struct {
      logic [31:0] instr;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [31:0] pc;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  ctl;
      logic        br;
      logic        ill;
   } vec_t;

   vec_t        vecs[NV];
   int          total;
   int          passed;
   logic [31:0] issue_log[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record operand a of every output transfer to verify ordering
   always @(posedge clk) begin
      if (out_valid && out_ready) issue_log.push_back(out_a);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, required %0h", name, act, exp);
   endtask

   task automatic drive(input logic [31:0] instr, input logic [31:0] rs1,
                        input logic [31:0] rs2, input logic [31:0] pc);
      in_instr = instr;
      in_rs1   = rs1;
      in_rs2   = rs2;
      in_pc    = pc;
      in_valid = 1'b1;
   endtask

   initial begin
      total = 0;
      passed = 0;
      //             instr          rs1           rs2           pc            a             b             ctl    br    ill
      vecs[0]  = '{32'h002081B3, 32'd5,        32'd7,        32'h0,        32'd5,        32'd7,        4'd8,  1'b0, 1'b0}; // add
      vecs[1]  = '{32'h4040D093, 32'h80000000, 32'h0,        32'h0,        32'h80000000, 32'd4,        4'd7,  1'b0, 1'b0}; // srai
      vecs[2]  = '{32'h0020E463, 32'd1,        32'd2,        32'h0,        32'd1,        32'd2,        4'd15, 1'b1, 1'b0}; // bltu
      vecs[3]  = '{32'h12345097, 32'h0,        32'h0,        32'h100,      32'h100,      32'h12345000, 4'd8,  1'b0, 1'b0}; // auipc
      vecs[4]  = '{32'h0000007F, 32'h11,       32'h22,       32'h33,       32'h0,        32'h0,        4'd0,  1'b0, 1'b1}; // bad opcode
      vecs[5]  = '{32'h402081B3, 32'd10,       32'd3,        32'h0,        32'd10,       32'd3,        4'd12, 1'b0, 1'b0}; // sub
      vecs[6]  = '{32'hFFF00093, 32'd9,        32'h0,        32'h0,        32'd9,        32'hFFFFFFFF, 4'd8,  1'b0, 1'b0}; // addi -1
      vecs[7]  = '{32'hFFFFF0B7, 32'h55,       32'h0,        32'h0,        32'h0,        32'hFFFFF000, 4'd8,  1'b0, 1'b0}; // lui
      vecs[8]  = '{32'h0000006F, 32'h0,        32'h0,        32'h200,      32'h200,      32'd4,        4'd8,  1'b0, 1'b0}; // jal
      vecs[9]  = '{32'hFE20AE23, 32'h1000,     32'h0,        32'h0,        32'h1000,     32'hFFFFFFFC, 4'd8,  1'b0, 1'b0}; // sw -4
      vecs[10] = '{32'h0020A463, 32'd1,        32'd2,        32'h0,        32'h0,        32'h0,        4'd0,  1'b0, 1'b1}; // branch f3=010
      vecs[11] = '{32'h022081B3, 32'd1,        32'd2,        32'h0,        32'h0,        32'h0,        4'd0,  1'b0, 1'b1}; // OP bad funct7
      vecs[12] = '{32'h40409093, 32'd1,        32'h0,        32'h0,        32'h0,        32'h0,        4'd0,  1'b0, 1'b1}; // slli bad funct7
      vecs[13] = '{32'h00208463, 32'd3,        32'd3,        32'h0,        32'd3,        32'd3,        4'd12, 1'b1, 1'b0}; // beq
      vecs[14] = '{32'h0020B1B3, 32'd4,        32'd6,        32'h0,        32'd4,        32'd6,        4'd15, 1'b0, 1'b0}; // sltu
      vecs[15] = '{32'h0020F1B3, 32'hF0,       32'h3C,       32'h0,        32'hF0,       32'h3C,       4'd1,  1'b0, 1'b0}; // and
      vecs[16] = '{32'h0020D1B3, 32'h80,       32'd3,        32'h0,        32'h80,       32'd3,        4'd6,  1'b0, 1'b0}; // srl

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_instr  = 32'h0;
      in_rs1    = 32'h0;
      in_rs2    = 32'h0;
      in_pc     = 32'h0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_a", 64'(out_a), 64'd0);
      check("rst_out_b", 64'(out_b), 64'd0);
      check("rst_ctl", 64'(out_control), 64'd0);
      check("rst_br_ill", 64'({out_is_branch, out_illegal}), 64'd0);

      // Back-to-back stream at full throughput
      @(negedge clk);
      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].instr, vecs[i].rs1, vecs[i].rs2, vecs[i].pc);
         @(negedge clk);
         check($sformatf("v%0d_valid", i), 64'(out_valid), 64'd1);
         check($sformatf("v%0d_a", i), 64'(out_a), 64'(vecs[i].a));
         check($sformatf("v%0d_b", i), 64'(out_b), 64'(vecs[i].b));
         check($sformatf("v%0d_ctl", i), 64'(out_control), 64'(vecs[i].ctl));
         check($sformatf("v%0d_br", i), 64'(out_is_branch), 64'(vecs[i].br));
         check($sformatf("v%0d_ill", i), 64'(out_illegal), 64'(vecs[i].ill));
         check($sformatf("v%0d_rdy", i), 64'(in_ready), 64'd1);
      end
      in_valid = 1'b0;
      @(negedge clk);
      check("stream_drained", 64'(out_valid), 64'd0);
      check("stream_count", 64'(issue_log.size()), 64'(NV));

      // Backpressure: three ops against a stalled consumer
      issue_log.delete();
      out_ready = 1'b0;
      drive(32'h002081B3, 32'd5, 32'd7, 32'h0);           // op1 add
      @(negedge clk);
      check("bp_valid1", 64'(out_valid), 64'd1);
      check("bp_a1", 64'(out_a), 64'd5);
      check("bp_rdy1", 64'(in_ready), 64'd1);
      drive(32'h402081B3, 32'd10, 32'd3, 32'h0);          // op2 sub
      @(negedge clk);
      check("bp_full_rdy", 64'(in_ready), 64'd0);
      check("bp_hold_a", 64'(out_a), 64'd5);
      check("bp_hold_b", 64'(out_b), 64'd7);
      drive(32'h12345097, 32'h0, 32'h0, 32'h100);         // op3 auipc
      @(negedge clk);
      check("bp_full_rdy2", 64'(in_ready), 64'd0);
      check("bp_hold_a2", 64'(out_a), 64'd5);
      check("bp_hold_ctl", 64'(out_control), 64'd8);
      @(negedge clk);
      check("bp_hold_a3", 64'(out_a), 64'd5);
      check("bp_hold_valid", 64'(out_valid), 64'd1);
`ifdef ALU_ISSUE_PERF_EN
      check("perf_stall3", 64'(perf_stall), 64'd3);
`endif
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_op2_a", 64'(out_a), 64'd10);
      check("bp_op2_ctl", 64'(out_control), 64'd12);
      check("bp_rdy_back", 64'(in_ready), 64'd1);
      @(negedge clk);
      check("bp_op3_a", 64'(out_a), 64'h100);
      check("bp_op3_b", 64'(out_b), 64'h12345000);
      in_valid = 1'b0;
      @(negedge clk);
      check("bp_drained", 64'(out_valid), 64'd0);
      check("bp_log_size", 64'(issue_log.size()), 64'd3);
      if (issue_log.size() == 3) begin
         check("bp_order0", 64'(issue_log[0]), 64'd5);
         check("bp_order1", 64'(issue_log[1]), 64'd10);
         check("bp_order2", 64'(issue_log[2]), 64'h100);
      end
`ifdef ALU_ISSUE_PERF_EN
      check("perf_issued", 64'(perf_issued), 64'(NV + 3));
      check("perf_stall_end", 64'(perf_stall), 64'd3);
`endif

      // Reset while both entries are occupied
      out_ready = 1'b0;
      drive(32'h002081B3, 32'd5, 32'd7, 32'h0);
      @(negedge clk);
      drive(32'h402081B3, 32'd10, 32'd3, 32'h0);
      @(negedge clk);
      check("rf_full", 64'(in_ready), 64'd0);
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("rf_async_valid", 64'(out_valid), 64'd0);
      check("rf_async_a", 64'(out_a), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rf_rel_rdy", 64'(in_ready), 64'd1);
      check("rf_rel_valid", 64'(out_valid), 64'd0);
`ifdef ALU_ISSUE_PERF_EN
      check("rf_perf_zero", 64'({perf_issued, perf_stall}), 64'd0);
`endif
      out_ready = 1'b1;
      @(negedge clk);
      drive(32'h002081B3, 32'd20, 32'd22, 32'h0);
      @(negedge clk);
      check("rf_post_valid", 64'(out_valid), 64'd1);
      check("rf_post_a", 64'(out_a), 64'd20);
      in_valid = 1'b0;
      @(negedge clk);
      check("rf_no_stale", 64'(out_valid), 64'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
